// File: rtl/axi4_lite_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_csr_bank
// Purpose  : AXI4-Lite slave exposing NUM_REGS 32-bit control (RW) or
//            status (RO) registers with byte strobes and write pulses.
// Revision : 1.0 - initial release
// ============================================================================

module axi4_lite_csr_bank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 12,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,

    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,

    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,

    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,

    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,

    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int         c_STRB_W      = DATA_WIDTH / 8;
    localparam int         c_IDX_W       = ADDR_WIDTH - 2;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_UPD  = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;
    localparam logic       c_R_IDLE = 1'b0;
    localparam logic       c_R_DATA = 1'b1;

    generate
        if (DATA_WIDTH != 32) begin : g_chk_data_width
            $error("axi4_lite_csr_bank: DATA_WIDTH must be 32");
        end
        if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_chk_num_regs
            $error("axi4_lite_csr_bank: NUM_REGS must be in 1..64");
        end
        if ((64'd1 << c_IDX_W) < 64'(NUM_REGS)) begin : g_chk_addr_space
            $error("axi4_lite_csr_bank: ADDR_WIDTH too small for NUM_REGS");
        end
    endgenerate

    logic [1:0]            wstate_q, wstate_d;
    logic                  rstate_q, rstate_d;

    logic                  aw_got_q, aw_got_d;
    logic                  w_got_q,  w_got_d;
    logic [c_IDX_W-1:0]    awidx_q,  awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [c_STRB_W-1:0]   wstrb_q,  wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q,  bresp_d;
    logic [NUM_REGS-1:0]   pulse_q,  pulse_d;
    logic [DATA_WIDTH-1:0] ctrl_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] ctrl_d [NUM_REGS];
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q,  rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic                  w_wr_ok;
    logic [c_IDX_W-1:0]    w_ar_idx;
    logic                  w_rd_ok;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_unused;

    assign w_aw_hs  = s_awvalid & w_awready;
    assign w_w_hs   = s_wvalid  & w_wready;
    assign w_ar_hs  = s_arvalid & w_arready;
    assign w_ar_idx = s_araddr[ADDR_WIDTH-1:2];
    assign w_wr_ok  = |w_wr_sel;

    // Byte lanes [1:0] of the address and RW status slots carry no meaning.
    assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0], status_i};

    // Address decode; only writable registers ever appear in w_wr_sel.
    always_comb begin
        w_wr_sel = '0;
        w_rd_ok  = 1'b0;
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (awidx_q == c_IDX_W'(i) && !RO_MASK[i]) begin
                w_wr_sel[i] = 1'b1;
            end
            if (w_ar_idx == c_IDX_W'(i)) begin
                w_rd_ok  = 1'b1;
                w_rd_val = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH]
                                      : ctrl_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q <= c_W_IDLE;
            rstate_q <= c_R_IDLE;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            c_W_IDLE: begin
                if ((aw_got_q || w_aw_hs) && (w_got_q || w_w_hs)) begin
                    wstate_d = c_W_UPD;
                end
            end
            c_W_UPD:  wstate_d = c_W_RESP;
            c_W_RESP: begin
                if (s_bready) begin
                    wstate_d = c_W_IDLE;
                end
            end
            default:  wstate_d = c_W_IDLE;
        endcase

        rstate_d = rstate_q;
        case (rstate_q)
            c_R_IDLE: begin
                if (w_ar_hs) begin
                    rstate_d = c_R_DATA;
                end
            end
            c_R_DATA: begin
                if (s_rready) begin
                    rstate_d = c_R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_awready = (wstate_q == c_W_IDLE) && !aw_got_q;
        w_wready  = (wstate_q == c_W_IDLE) && !w_got_q;
        w_arready = (rstate_q == c_R_IDLE);

        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awidx_d  = awidx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        if (w_aw_hs) begin
            aw_got_d = 1'b1;
            awidx_d  = s_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_w_hs) begin
            w_got_d = 1'b1;
            wdata_d = s_wdata;
            wstrb_d = s_wstrb;
        end

        ctrl_d   = ctrl_q;
        pulse_d  = '0;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wstate_q == c_W_UPD) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            pulse_d  = w_wr_sel;
            bvalid_d = 1'b1;
            bresp_d  = w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < c_STRB_W; b++) begin
                    if (w_wr_sel[i] && wstrb_q[b]) begin
                        ctrl_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                end
            end
        end else if (wstate_q == c_W_RESP && s_bready) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = w_rd_ok ? c_RESP_OKAY : c_RESP_SLVERR;
            rdata_d  = w_rd_val;
        end else if (rstate_q == c_R_DATA && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            awidx_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= c_RESP_OKAY;
            pulse_q  <= '0;
            rvalid_q <= 1'b0;
            rresp_q  <= c_RESP_OKAY;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                ctrl_q[i] <= '0;
            end
        end else begin
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            awidx_q  <= awidx_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            pulse_q  <= pulse_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                ctrl_q[i] <= ctrl_d[i];
            end
        end
    end

    assign s_awready  = w_awready;
    assign s_wready   = w_wready;
    assign s_arready  = w_arready;
    assign s_bvalid   = bvalid_q;
    assign s_bresp    = bresp_q;
    assign s_rvalid   = rvalid_q;
    assign s_rresp    = rresp_q;
    assign s_rdata    = rdata_q;
    assign wr_pulse_o = pulse_q;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_ctrl
            if (RO_MASK[i]) begin : g_ro
                assign ctrl_o[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else begin : g_rw
                assign ctrl_o[i*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[i];
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_csr_bank
// Purpose  : Directed self-checking bench for axi4_lite_csr_bank (8 regs,
//            register 7 read-only).
// Revision : 1.0 - initial release
// ============================================================================

module tb_axi4_lite_csr_bank;

    logic         clk;
    logic         rst;
    logic [11:0]  s_awaddr;
    logic         s_awvalid;
    logic         s_awready;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wvalid;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready;
    logic [11:0]  s_araddr;
    logic         s_arvalid;
    logic         s_arready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rvalid;
    logic         s_rready;
    logic [255:0] ctrl_o;
    logic [255:0] status_i;
    logic [7:0]   wr_pulse_o;

    int           checks;
    int           failures;
    logic [1:0]   resp;
    logic [7:0]   pulse;
    logic [31:0]  data;
    logic [255:0] exp_ctrl;

    axi4_lite_csr_bank #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .NUM_REGS   (8),
        .RO_MASK    (8'h80)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_awaddr   (s_awaddr),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_bresp    (s_bresp),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .ctrl_o     (ctrl_o),
        .status_i   (status_i),
        .wr_pulse_o (wr_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] r, output logic [7:0] p);
        int n;
        bit aw_done, w_done, aw_hs, w_hs;
        s_awaddr  = a;
        s_awvalid = 1'b1;
        s_wdata   = d;
        s_wstrb   = s;
        s_wvalid  = 1'b1;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        n         = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick();
            if (aw_hs) begin aw_done = 1'b1; s_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; s_wvalid  = 1'b0; end
            n++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("wr_accept", {aw_done, w_done}, 2'b11);
        n = 0;
        while (!s_bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("wr_bvalid_seen", s_bvalid, 1'b1);
        r = s_bresp;
        p = wr_pulse_o;
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("wr_b_stall", {s_bvalid, s_bresp, s_awready, s_wready, wr_pulse_o},
                {1'b1, r, 2'b00, 8'h00});
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("wr_b_done", {s_bvalid, wr_pulse_o}, 9'h000);
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] r);
        int n;
        bit done, hs;
        s_araddr  = a;
        s_arvalid = 1'b1;
        done      = 1'b0;
        n         = 0;
        while (!done && n < 20) begin
            hs = s_arready;
            tick();
            if (hs) begin done = 1'b1; s_arvalid = 1'b0; end
            n++;
        end
        s_arvalid = 1'b0;
        chk("rd_accept", done, 1'b1);
        n = 0;
        while (!s_rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_rvalid_seen", s_rvalid, 1'b1);
        d = s_rdata;
        r = s_rresp;
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("rd_r_stall", {s_rvalid, s_rresp, s_arready, s_rdata}, {1'b1, r, 1'b0, d});
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("rd_r_done", {s_rvalid, s_arready}, 2'b01);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        status_i  = '0;
        status_i[0*32 +: 32] = 32'hDEADBEEF;
        status_i[2*32 +: 32] = 32'h77777777;
        status_i[7*32 +: 32] = 32'hCAFEF00D;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
        chk("rst_valid", {s_bvalid, s_rvalid}, 2'b00);
        chk("rst_resp", {s_bresp, s_rresp}, 4'h0);
        chk("rst_rdata", s_rdata, 32'h0);
        chk("rst_pulse", wr_pulse_o, 8'h00);
        chk("rst_ctrl", ctrl_o, 256'h0);
        rst = 1'b0;
        tick();

        // Full-word write and readback of reg 0
        axi_write(12'h000, 32'hAAAAAAAA, 4'hF, 0, resp, pulse);
        chk("w0_bresp", resp, 2'b00);
        chk("w0_pulse", pulse, 8'h01);
        chk("w0_ctrl", ctrl_o[31:0], 32'hAAAAAAAA);
        axi_read(12'h000, 0, data, resp);
        chk("r0_rdata", data, 32'hAAAAAAAA);
        chk("r0_rresp", resp, 2'b00);

        // W three cycles ahead of AW, partial strobes onto preset reg 2
        axi_write(12'h008, 32'hFFFFFFFF, 4'hF, 0, resp, pulse);
        chk("preset_reg2", ctrl_o[95:64], 32'hFFFFFFFF);
        s_wdata  = 32'h12345678;
        s_wstrb  = 4'h5;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        chk("wfirst_ready", {s_awready, s_wready}, 2'b10);
        tick();
        tick();
        chk("wfirst_no_b_yet", s_bvalid, 1'b0);
        s_awaddr  = 12'h008;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        chk("wfirst_b_not_early", s_bvalid, 1'b0);
        tick();
        chk("wfirst_b", {s_bvalid, s_bresp}, 3'b100);
        chk("wfirst_pulse", wr_pulse_o, 8'h04);
        chk("wfirst_reg2", ctrl_o[95:64], 32'hFF34FF78);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("wfirst_single_b", {s_bvalid, wr_pulse_o}, 9'h000);

        // Zero strobes: OKAY and pulse, data untouched
        axi_write(12'h000, 32'h11111111, 4'h0, 0, resp, pulse);
        chk("wstrb0_bresp", resp, 2'b00);
        chk("wstrb0_pulse", pulse, 8'h01);
        chk("wstrb0_reg0", ctrl_o[31:0], 32'hAAAAAAAA);

        exp_ctrl = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF34FF78, 32'h0, 32'hAAAAAAAA};

        // Out-of-range index
        axi_write(12'h020, 32'h55555555, 4'hF, 0, resp, pulse);
        chk("oor_bresp", resp, 2'b10);
        chk("oor_pulse", pulse, 8'h00);
        chk("oor_ctrl", ctrl_o, exp_ctrl);
        axi_read(12'h020, 0, data, resp);
        chk("oor_rdata", data, 32'h0);
        chk("oor_rresp", resp, 2'b10);

        // Read-only register 7 and status ignored on RW slot 2
        axi_read(12'h01C, 0, data, resp);
        chk("ro_rdata", data, 32'hCAFEF00D);
        chk("ro_rresp", resp, 2'b00);
        axi_read(12'h008, 0, data, resp);
        chk("rw2_rdata", data, 32'hFF34FF78);
        axi_write(12'h01C, 32'h12345678, 4'hF, 0, resp, pulse);
        chk("ro_bresp", resp, 2'b10);
        chk("ro_pulse", pulse, 8'h00);
        chk("ro_ctrl", ctrl_o, exp_ctrl);

        // Backpressure on B and R for five cycles each
        axi_write(12'h004, 32'h0000BEEF, 4'h3, 5, resp, pulse);
        chk("stall_bresp", resp, 2'b00);
        chk("stall_pulse", pulse, 8'h02);
        chk("stall_reg1", ctrl_o[63:32], 32'h0000BEEF);
        axi_read(12'h004, 5, data, resp);
        chk("stall_rdata", data, 32'h0000BEEF);
        chk("stall_rresp", resp, 2'b00);

        // Read sampled on the same edge as a write update sees the old value
        axi_write(12'h00C, 32'h13579BDF, 4'hF, 0, resp, pulse);
        chk("pre_sim_pulse", pulse, 8'h08);
        s_awaddr  = 12'h00C;
        s_awvalid = 1'b1;
        s_wdata   = 32'h2468ACE0;
        s_wstrb   = 4'hF;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_araddr  = 12'h00C;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("sim_valids", {s_bvalid, s_rvalid}, 2'b11);
        chk("sim_rdata_old", s_rdata, 32'h13579BDF);
        chk("sim_ctrl_new", ctrl_o[127:96], 32'h2468ACE0);
        s_bready = 1'b1;
        s_rready = 1'b1;
        tick();
        s_bready = 1'b0;
        s_rready = 1'b0;
        chk("sim_done", {s_bvalid, s_rvalid}, 2'b00);

        // Reset after AW captured, before W
        s_awaddr  = 12'h00C;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        chk("aw_only_ready", {s_awready, s_wready}, 2'b01);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
        chk("mid_rst_outs", {s_bvalid, s_rvalid, s_bresp, s_rresp, wr_pulse_o}, 14'h0);
        chk("mid_rst_ctrl", ctrl_o, 256'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", {s_bvalid, wr_pulse_o, s_awready, s_wready}, 11'b0_00000000_11);
        axi_write(12'h00C, 32'h0F0F0F0F, 4'hF, 0, resp, pulse);
        chk("post_rst_bresp", resp, 2'b00);
        chk("post_rst_pulse", pulse, 8'h08);
        chk("post_rst_ctrl", ctrl_o, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0F0F0F0F, 96'h0});
        axi_read(12'h00C, 0, data, resp);
        chk("post_rst_rdata", data, 32'h0F0F0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
